// File: rtl/spr_dma_ctrl_if.sv
// rtl/spr_dma_ctrl_if.sv - Snooped arbiter bus plus sprite-master port of the OAM DMA engine
// master = DMA engine side, slave = arbiter side.
interface spr_dma_ctrl_if;
  logic [15:0] i_bus_addr;
  logic [7:0]  i_bus_wdata;
  logic        i_bus_wn;
  logic        o_spr_req;
  logic        i_spr_gnt;
  logic [15:0] o_spr_addr;
  logic        o_spr_wn;
  logic [7:0]  o_spr_wdata;
  logic [7:0]  i_spr_rdata;
  logic        o_busy;

  modport master (
    input  i_bus_addr, i_bus_wdata, i_bus_wn, i_spr_gnt, i_spr_rdata,
    output o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy
  );

  modport slave (
    output i_bus_addr, i_bus_wdata, i_bus_wn, i_spr_gnt, i_spr_rdata,
    input  o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy
  );
endinterface

// File: rtl/spr_dma_ctrl.sv
// rtl/spr_dma_ctrl.sv - Sprite OAM DMA: snoops a $4014 write, copies one CPU page into $2004
// Define SPR_DMA_ALIGN_EN to add the odd-cycle ALIGN state driven by a free-running parity bit.
module spr_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic           i_clk,
  input  logic           i_rst,
  spr_dma_ctrl_if.master bus
);

`ifdef SPR_DMA_ALIGN_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ALIGN, S_READ, S_WRITE, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WRITE, S_DONE} state_e;
`endif

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_e      state_q;
  logic [7:0]  index_q;
  logic [7:0]  page_q;
  logic [7:0]  wdata_q;
  logic [15:0] addr_q;
  logic        req_q;
  logic        wn_q;
  logic        busy_q;
  logic        trigger_d;
  logic [7:0]  index_d;
`ifdef SPR_DMA_ALIGN_EN
  logic        parity_q;
`endif

  assign trigger_d = !bus.i_bus_wn && (bus.i_bus_addr == DMA_REG_ADDR);
  assign index_d   = index_q + 8'd1;

  // Outputs are registered: each transition loads the values for the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      index_q  <= 8'h00;
      page_q   <= 8'h00;
      wdata_q  <= 8'h00;
      addr_q   <= 16'h0000;
      req_q    <= 1'b0;
      wn_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef SPR_DMA_ALIGN_EN
      parity_q <= 1'b0;
`endif
    end else begin
`ifdef SPR_DMA_ALIGN_EN
      parity_q <= ~parity_q;
`endif
      case (state_q)
        S_IDLE: begin
          if (trigger_d) begin
            page_q  <= bus.i_bus_wdata;
            index_q <= 8'h00;
            req_q   <= 1'b1;
            wn_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.i_spr_gnt) begin
`ifdef SPR_DMA_ALIGN_EN
            if (parity_q) begin
              state_q <= S_ALIGN;
            end else begin
              addr_q  <= {page_q, index_q};
              state_q <= S_READ;
            end
`else
            addr_q  <= {page_q, index_q};
            state_q <= S_READ;
`endif
          end
        end
`ifdef SPR_DMA_ALIGN_EN
        S_ALIGN: begin
          if (bus.i_spr_gnt) begin
            addr_q  <= {page_q, index_q};
            state_q <= S_READ;
          end
        end
`endif
        S_READ: begin
          if (bus.i_spr_gnt) begin
            wdata_q <= bus.i_spr_rdata;
            addr_q  <= OAM_DATA_ADDR;
            wn_q    <= 1'b0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.i_spr_gnt) begin
            index_q <= index_d;
            wn_q    <= 1'b1;
            if (index_q == LAST_IDX) begin
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              addr_q  <= {page_q, index_d};
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_spr_req   = req_q;
  assign bus.o_spr_addr  = addr_q;
  assign bus.o_spr_wn    = wn_q;
  assign bus.o_spr_wdata = wdata_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_spr_dma_ctrl.sv
// tb/tb_spr_dma_ctrl.sv - Scoreboard bench for the sprite OAM DMA engine
// The bench plays the bus arbiter and a CPU RAM whose contents are a fixed function of address.
module tb_spr_dma_ctrl;
  localparam int XFER = 256;
`ifdef SPR_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spr_dma_ctrl_if bus_if ();
  spr_dma_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus_if));

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h02);
  endfunction

  logic [15:0] cpu_addr  = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_wn    = 1'b1;
  logic        gnt       = 1'b1;
  logic        gnt_base  = 1'b1;
  logic        own;

  // Arbiter output bus shows the DMA while it owns the bus, otherwise the CPU.
  assign own                = bus_if.o_spr_req && gnt;
  assign bus_if.i_bus_addr  = own ? bus_if.o_spr_addr  : cpu_addr;
  assign bus_if.i_bus_wdata = own ? bus_if.o_spr_wdata : cpu_wdata;
  assign bus_if.i_bus_wn    = own ? bus_if.o_spr_wn    : cpu_wn;
  assign bus_if.i_spr_gnt   = gnt;
  assign bus_if.i_spr_rdata = mem_rd(bus_if.o_spr_addr);

  int   cyc   = 0;
  logic par_m = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    par_m <= rst ? 1'b0 : ~par_m;
  end

  int checks = 0;
  int errors = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [23:0] exp_q[$];
  logic [15:0] last_rd = 16'h0000;
  int   wr_cnt = 0, lw_cyc = 0, req_cnt = 0, rise_cyc = 0, fall_cyc = 0, fall_cnt = 0;
  int   trig_cyc = 0, req_base = 0, wr_base = 0, drop_cnt = 0;
  logic cap_par = 1'b0, req_prev = 1'b0, busy_prev = 1'b0;
  logic drop_en = 1'b0, d40 = 1'b0, d41 = 1'b0;
  logic [7:0] drop_pg = 8'h02;

  // One clock: pick this cycle's grant, observe the DUT at negedge, return just after posedge.
  task automatic step();
    logic [23:0] e;
    @(negedge clk);
    if (drop_cnt > 0) begin
      gnt = 1'b0;
      drop_cnt--;
    end else begin
      gnt = gnt_base;
    end
    if (drop_en && !d40 && bus_if.o_spr_req && bus_if.o_spr_wn &&
        bus_if.o_spr_addr == {drop_pg, 8'h40}) begin
      gnt = 1'b0; drop_cnt = 2; d40 = 1'b1;
    end
    if (drop_en && !d41 && bus_if.o_spr_req && !bus_if.o_spr_wn &&
        last_rd == {drop_pg, 8'h41}) begin
      gnt = 1'b0; drop_cnt = 4; d41 = 1'b1;
    end
    if (!rst) begin
      if (!gnt && bus_if.o_busy) check_eq("req_hold", 32'(bus_if.o_spr_req), 1);
      if (bus_if.o_spr_req && gnt) begin
        if (bus_if.o_spr_wn) begin
          last_rd = bus_if.o_spr_addr;
        end else begin
          wr_cnt++;
          lw_cyc = cyc;
          if (exp_q.size() == 0) begin
            check_eq("extra_write", wr_cnt, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("rd_addr", 32'(last_rd), 32'(e[23:8]));
            check_eq("wr_addr", 32'(bus_if.o_spr_addr), 32'h2004);
            check_eq("wr_data", 32'(bus_if.o_spr_wdata), 32'(e[7:0]));
          end
        end
      end
      if (bus_if.o_spr_req) req_cnt++;
      if (bus_if.o_spr_req && !req_prev) begin
        rise_cyc = cyc;
        cap_par  = par_m;
      end
      if (!bus_if.o_busy && busy_prev) begin
        fall_cyc = cyc;
        fall_cnt++;
      end
    end
    req_prev  = bus_if.o_spr_req;
    busy_prev = bus_if.o_busy;
    @(posedge clk);
    #1;
  endtask

  // want is the parity required in the first granted REQ cycle (trigger cycle + 1).
  task automatic start_dma(input logic [7:0] pg, input bit use_par, input logic want);
    if (use_par && par_m == want) step();
    for (int i = 0; i < XFER; i++) exp_q.push_back({pg, 8'(i), mem_rd({pg, 8'(i)})});
    trig_cyc  = cyc;
    req_base  = req_cnt;
    wr_base   = wr_cnt;
    cpu_addr  = 16'h4014;
    cpu_wn    = 1'b0;
    cpu_wdata = pg;
    step();
    cpu_addr  = 16'h0000;
    cpu_wn    = 1'b1;
    cpu_wdata = 8'h00;
  endtask

  task automatic wait_done();
    int base  = fall_cnt;
    int guard = 0;
    while (fall_cnt == base && guard < 2000) begin
      step();
      guard++;
    end
    check_eq("done_timeout", 32'(fall_cnt != base), 1);
  endtask

  task automatic check_xfer(input int drops);
    int exp_len;
    exp_len = 2 * XFER + 1 + ((ALIGN_EN && cap_par) ? 1 : 0);
    check_eq("req_rise",   rise_cyc - trig_cyc, 1);
    check_eq("req_cycles", req_cnt - req_base, exp_len + drops);
    check_eq("wr_count",   wr_cnt - wr_base, XFER);
    check_eq("busy_fall",  fall_cyc - lw_cyc, 1);
    check_eq("sb_empty",   exp_q.size(), 0);
  endtask

  initial begin
    int guard;
    repeat (3) step();
    check_eq("rst_req",   32'(bus_if.o_spr_req), 0);
    check_eq("rst_addr",  32'(bus_if.o_spr_addr), 0);
    check_eq("rst_wn",    32'(bus_if.o_spr_wn), 1);
    check_eq("rst_wdata", 32'(bus_if.o_spr_wdata), 0);
    check_eq("rst_busy",  32'(bus_if.o_busy), 0);
    rst = 1'b0;
    repeat (2) step();

    start_dma(8'h02, 1'b1, 1'b1); wait_done(); check_xfer(0);
    repeat (3) step();
    start_dma(8'h02, 1'b1, 1'b0); wait_done(); check_xfer(0);
    repeat (3) step();

    drop_pg = 8'h02; drop_en = 1'b1; d40 = 1'b0; d41 = 1'b0;
    start_dma(8'h02, 1'b0, 1'b0); wait_done(); check_xfer(8);
    check_eq("drops_seen", 32'(d40 && d41), 1);
    drop_en = 1'b0;
    repeat (3) step();

    start_dma(8'hFF, 1'b0, 1'b0); wait_done(); check_xfer(0);
    repeat (3) step();

    start_dma(8'h02, 1'b0, 1'b0);
    repeat (50) step();
    gnt_base = 1'b0; cpu_addr = 16'h4014; cpu_wn = 1'b0; cpu_wdata = 8'h03;
    step();
    gnt_base = 1'b1; cpu_addr = 16'h0000; cpu_wn = 1'b1; cpu_wdata = 8'h00;
    wait_done(); check_xfer(1);
    repeat (5) step();
    check_eq("no_retrigger", 32'(bus_if.o_busy), 0);

    start_dma(8'h02, 1'b0, 1'b0);
    guard = 0;
    while (wr_cnt - wr_base < 100 && guard < 1000) begin
      step();
      guard++;
    end
    check_eq("mid_timeout", 32'(wr_cnt - wr_base), 100);
    rst = 1'b1;
    step();
    check_eq("mid_req",   32'(bus_if.o_spr_req), 0);
    check_eq("mid_busy",  32'(bus_if.o_busy), 0);
    check_eq("mid_wn",    32'(bus_if.o_spr_wn), 1);
    check_eq("mid_addr",  32'(bus_if.o_spr_addr), 0);
    check_eq("mid_wdata", 32'(bus_if.o_spr_wdata), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) step();
    start_dma(8'h02, 1'b0, 1'b0); wait_done(); check_xfer(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
